// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - rename-stage sizing parameters and shared types
package rename_pkg;
  localparam int MACHINE_WIDTH = 4;
  localparam int PRF_DEPTH     = 64;
  localparam int ARF_DEPTH     = 32;
  localparam int PRF_WIDTH     = 6;
  localparam int FL_DEPTH      = PRF_DEPTH - ARF_DEPTH;
  localparam int FL_IDX_W      = $clog2(FL_DEPTH);
  localparam int FL_PTR_W      = FL_IDX_W + 1;
  localparam int LANE_CNT_W    = $clog2(MACHINE_WIDTH) + 1;

  typedef logic [PRF_WIDTH-1:0]  prn_t;
  typedef logic [FL_PTR_W-1:0]   fl_ptr_t;
  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;
endpackage

// File: rtl/lane_compact.sv
// rtl/lane_compact.sv - exclusive prefix popcount: sparse lane mask to dense offsets plus total
module lane_compact
  import rename_pkg::*;
(
  input  logic [MACHINE_WIDTH-1:0] valid_i,
  output lane_cnt_t [MACHINE_WIDTH-1:0] offset_o,
  output lane_cnt_t                     count_o
);

  lane_cnt_t acc;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      offset_o[i] = acc;
      acc         = acc + lane_cnt_t'(valid_i[i]);
    end
    count_o = acc;
  end

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free PRN list with arch-head flush recovery (optional FREE_LIST_OCCUPANCY_EN)
module free_list
  import rename_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_flush,
  output prn_t [MACHINE_WIDTH-1:0] free_prn,
  output logic [MACHINE_WIDTH-1:0] free_prn_valid,
  input  logic [MACHINE_WIDTH-1:0] free_prn_ready,
  input  prn_t [MACHINE_WIDTH-1:0] retire_prn,
  input  logic [MACHINE_WIDTH-1:0] retire_valid
`ifdef FREE_LIST_OCCUPANCY_EN
  ,
  output fl_ptr_t                  free_count,
  output logic                     free_low
`endif
);

  prn_t [FL_DEPTH-1:0] entry_q;
  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t arch_head_q, arch_head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t occupancy;

  logic [MACHINE_WIDTH-1:0] alloc_mask;
  lane_cnt_t [MACHINE_WIDTH-1:0] alloc_off, ret_off;
  lane_cnt_t n_alloc, n_ret;
  logic alloc_dense;

  always_comb begin
    occupancy      = tail_q - spec_head_q;
    free_prn       = '0;
    free_prn_valid = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      free_prn[i]       = entry_q[spec_head_q[FL_IDX_W-1:0] + FL_IDX_W'(i)];
      free_prn_valid[i] = occupancy > FL_PTR_W'(i);
    end
  end

  assign alloc_mask = free_prn_valid & free_prn_ready;

  lane_compact u_alloc_compact (
    .valid_i  (alloc_mask),
    .offset_o (alloc_off),
    .count_o  (n_alloc)
  );

  lane_compact u_ret_compact (
    .valid_i  (retire_valid),
    .offset_o (ret_off),
    .count_o  (n_ret)
  );

  // A flush rewinds to the retired head including this cycle's retirements.
  always_comb begin
    tail_d      = tail_q + FL_PTR_W'(n_ret);
    arch_head_d = arch_head_q + FL_PTR_W'(n_ret);
    spec_head_d = pipe_flush ? arch_head_d : spec_head_q + FL_PTR_W'(n_alloc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        entry_q[k] <= prn_t'(ARF_DEPTH + k);
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(FL_DEPTH);
    end else begin
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (retire_valid[i]) begin
          entry_q[tail_q[FL_IDX_W-1:0] + FL_IDX_W'(ret_off[i])] <= retire_prn[i];
        end
      end
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

`ifdef FREE_LIST_OCCUPANCY_EN
  fl_ptr_t free_count_q, free_count_d;

  always_comb begin
    if (pipe_flush) begin
      free_count_d = tail_q - arch_head_q;
    end else begin
      free_count_d = free_count_q + FL_PTR_W'(n_ret) - FL_PTR_W'(n_alloc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_count_q <= fl_ptr_t'(FL_DEPTH);
    end else begin
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;
  assign free_low   = free_count_q < FL_PTR_W'(2 * MACHINE_WIDTH);
`endif

  // Accepted lanes must be dense from lane 0, i.e. ready is a thermometer.
  always_comb begin
    alloc_dense = 1'b1;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (alloc_mask[i] && (alloc_off[i] != lane_cnt_t'(i))) alloc_dense = 1'b0;
    end
  end

  a_ready_prefix: assert property (@(posedge clk) disable iff (rst) alloc_dense);
  a_ready_valid: assert property (@(posedge clk) disable iff (rst)
    (occupancy == '0) || ((free_prn_ready & ~free_prn_valid) == '0));
  a_arch_behind_spec: assert property (@(posedge clk) disable iff (rst)
    fl_ptr_t'(spec_head_q - arch_head_q) <= fl_ptr_t'(FL_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    occupancy <= fl_ptr_t'(FL_DEPTH));

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed table-driven bench for free_list plus wrap and async-reset sequences
module tb_free_list;

  logic            clk;
  logic            rst;
  logic            pipe_flush;
  logic [3:0][5:0] free_prn;
  logic [3:0]      free_prn_valid;
  logic [3:0]      free_prn_ready;
  logic [3:0][5:0] retire_prn;
  logic [3:0]      retire_valid;
`ifdef FREE_LIST_OCCUPANCY_EN
  logic [5:0]      free_count;
  logic            free_low;
`endif

  free_list dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_flush     (pipe_flush),
    .free_prn       (free_prn),
    .free_prn_valid (free_prn_valid),
    .free_prn_ready (free_prn_ready),
    .retire_prn     (retire_prn),
    .retire_valid   (retire_valid)
`ifdef FREE_LIST_OCCUPANCY_EN
    ,
    .free_count     (free_count),
    .free_low       (free_low)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic [3:0]  ready;
    logic [3:0]  rvalid;
    logic [23:0] rprn;
    logic [23:0] exp_prn;
    logic [3:0]  exp_valid;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [23:0] pk(int a, int b, int c, int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic add(string n, logic r, logic f, logic [3:0] rd, logic [3:0] rv,
                     logic [23:0] rp, logic [23:0] ep, logic [3:0] ev, int ec);
    vec_t v;
    v.name = n; v.rst = r; v.flush = f; v.ready = rd; v.rvalid = rv;
    v.rprn = rp; v.exp_prn = ep; v.exp_valid = ev; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic check(string n, logic [23:0] act, logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%06h expected 0x%06h", n, act, exp);
  endtask

  task automatic drive(logic r, logic f, logic [3:0] rd, logic [3:0] rv, logic [23:0] rp);
    rst = r; pipe_flush = f; free_prn_ready = rd; retire_valid = rv; retire_prn = rp;
  endtask

  int fq[$];
  int aq[$];
  int al[4];
  int rt[4];

  initial begin
    drive(1'b1, 1'b0, 4'h0, 4'h0, '0);

    add("reset", 1, 0, 4'h0, 4'h0, 0, pk(32, 33, 34, 35), 4'hf, 32);
    for (int k = 0; k < 10; k++)
      add($sformatf("idle%0d", k), 0, 0, 4'h0, 4'h0, 0, pk(32, 33, 34, 35), 4'hf, 32);
    add("alloc2", 0, 0, 4'b0011, 4'h0, 0, pk(34, 35, 36, 37), 4'hf, 30);

    add("reset2", 1, 0, 4'h0, 4'h0, 0, pk(32, 33, 34, 35), 4'hf, 32);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        add($sformatf("drain%0d", k), 0, 0, 4'hf, 4'h0, 0,
            pk(32 + 4*k, 33 + 4*k, 34 + 4*k, 35 + 4*k), 4'hf, 32 - 4*k);
      else
        add("drain_empty", 0, 0, 4'hf, 4'h0, 0, pk(32, 33, 34, 35), 4'h0, 0);
    end
    add("retire_sparse", 0, 0, 4'h0, 4'b0101, pk(5, 63, 9, 62), pk(5, 9, 34, 35), 4'b0011, 2);

    add("reset3", 1, 0, 4'h0, 4'h0, 0, pk(32, 33, 34, 35), 4'hf, 32);
    add("alloc4a", 0, 0, 4'hf, 4'h0, 0, pk(36, 37, 38, 39), 4'hf, 28);
    add("alloc4b", 0, 0, 4'hf, 4'h0, 0, pk(40, 41, 42, 43), 4'hf, 24);
    add("flush_ret3", 0, 1, 4'h0, 4'b0111, pk(1, 2, 3, 0), pk(35, 36, 37, 38), 4'hf, 32);
    add("flush_drop_alloc", 0, 1, 4'hf, 4'b0001, pk(7, 0, 0, 0), pk(36, 37, 38, 39), 4'hf, 32);
    for (int k = 1; k <= 7; k++) begin
      if (k < 7)
        add($sformatf("redrain%0d", k), 0, 0, 4'hf, 4'h0, 0,
            pk(36 + 4*k, 37 + 4*k, 38 + 4*k, 39 + 4*k), 4'hf, 32 - 4*k);
      else
        add("redrain_retired", 0, 0, 4'hf, 4'h0, 0, pk(1, 2, 3, 7), 4'hf, 4);
    end
    add("redrain_empty", 0, 0, 4'hf, 4'h0, 0, pk(36, 37, 38, 39), 4'h0, 0);
    add("flush_restore", 0, 1, 4'h0, 4'h0, 0, pk(36, 37, 38, 39), 4'hf, 32);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].ready, vecs[i].rvalid, vecs[i].rprn);
      @(negedge clk);
      check({vecs[i].name, ".prn"}, free_prn, vecs[i].exp_prn);
      check({vecs[i].name, ".valid"}, {20'd0, free_prn_valid}, {20'd0, vecs[i].exp_valid});
`ifdef FREE_LIST_OCCUPANCY_EN
      check({vecs[i].name, ".count"}, {18'd0, free_count}, 24'(vecs[i].exp_cnt));
      check({vecs[i].name, ".low"}, {23'd0, free_low}, {23'd0, vecs[i].exp_cnt < 8});
`endif
    end

    // Steady-state rotation: allocate 4 and retire 4 stale PRNs per cycle.
    drive(1'b1, 1'b0, 4'h0, 4'h0, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'h0, '0);
    for (int k = 0; k < 32; k++) begin
      fq.push_back(32 + k);
      aq.push_back(k);
    end
    for (int c = 0; c < 40; c++) begin
      check($sformatf("wrap%0d.prn", c), free_prn, pk(fq[0], fq[1], fq[2], fq[3]));
      check($sformatf("wrap%0d.valid", c), {20'd0, free_prn_valid}, 24'h00000f);
      for (int j = 0; j < 4; j++) begin
        al[j] = fq.pop_front();
        rt[j] = aq.pop_front();
      end
      drive(1'b0, 1'b0, 4'hf, 4'hf, pk(rt[0], rt[1], rt[2], rt[3]));
      for (int j = 0; j < 4; j++) begin
        fq.push_back(rt[j]);
        aq.push_back(al[j]);
      end
      @(negedge clk);
    end
    check("wrap_end.prn", free_prn, pk(fq[0], fq[1], fq[2], fq[3]));
`ifdef FREE_LIST_OCCUPANCY_EN
    check("wrap_end.count", {18'd0, free_count}, 24'd32);
`endif

    // Reset asserted between edges must take effect immediately.
    drive(1'b0, 1'b0, 4'h0, 4'h0, '0);
    #2 rst = 1'b1;
    #1;
    check("async_reset.prn", free_prn, pk(32, 33, 34, 35));
    check("async_reset.valid", {20'd0, free_prn_valid}, 24'h00000f);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
